// File: rtl/div_share_pkg.sv
// div_share_pkg: shared types and constants for the divider share arbiter.
//   state_t  : arbiter FSM state (2-bit)
//   id_width : requester tag width for a given requester count (min 1)
//   QM/QN/ONE: Q12.20 format constants
package div_share_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, BUSY = 2'd2, RESP = 2'd3} state_t;
   localparam int QM = 12;
   localparam int QN = 20;
   localparam logic [31:0] ONE = 32'h0010_0000;
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/divider_share_arbiter_rr_grant.sv
// rr_grant: combinational round-robin priority encoder.
//   req       in  NUM_REQ   request vector
//   ptr       in  ID_WIDTH  highest-priority index this round
//   grant     out NUM_REQ   one-hot grant (all 0 when nothing requests)
//   winner    out ID_WIDTH  index of the granted requester
//   any_valid out 1         at least one request is present
module rr_grant #(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = 2
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] ptr,
   output logic [NUM_REQ-1:0]  grant,
   output logic [ID_WIDTH-1:0] winner,
   output logic                any_valid
);
   // Scan from the farthest position back toward ptr so the nearest
   // requester at or after ptr is the last (winning) assignment.
   always_comb begin
      winner    = '0;
      any_valid = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[(int'(ptr) + k) % NUM_REQ]) begin
            winner    = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
            any_valid = 1'b1;
         end
      end
      grant         = '0;
      grant[winner] = any_valid;
   end
endmodule

// File: rtl/divider_share_arbiter.sv
// divider_share_arbiter: shares one iterative Q12.20 divider between NUM_REQ
// requesters, round-robin, one operation in flight.
//   clk, arst_n                   clock, asynchronous active-low reset
//   req_valid/req_ready           per-requester request handshake
//   req_num/req_den               packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rsp_valid/rsp_ready           response handshake
//   rsp_id/rsp_quotient/rsp_error response tag, quotient, error
//   div_in_valid/div_numerator/div_denominator  start pulse and operands to the divider
//   div_out_valid/div_quotient/div_error        completion from the divider
// Optional: define DIV_SHARE_TIMEOUT_EN to add a BUSY watchdog of TIMEOUT_CYCLES
// that returns rsp_error=1, rsp_quotient=0 when the divider never answers.
module divider_share_arbiter
   import div_share_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int ID_WIDTH       = id_width(NUM_REQ),
   parameter int TIMEOUT_CYCLES = 128
) (
   input  logic                          clk,
   input  logic                          arst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_num,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_den,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [ID_WIDTH-1:0]           rsp_id,
   output logic [DATA_WIDTH-1:0]         rsp_quotient,
   output logic                          rsp_error,
   output logic                          div_in_valid,
   output logic [DATA_WIDTH-1:0]         div_numerator,
   output logic [DATA_WIDTH-1:0]         div_denominator,
   input  logic                          div_out_valid,
   input  logic [DATA_WIDTH-1:0]         div_quotient,
   input  logic                          div_error
);
   state_t              state, state_nxt;
   logic [ID_WIDTH-1:0] ptr, id_q, winner;
   logic [NUM_REQ-1:0]  grant;
   logic                any_valid, take, done, tmo;

   rr_grant #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_rr (
      .req(req_valid), .ptr(ptr), .grant(grant), .winner(winner), .any_valid(any_valid)
   );

   assign req_ready = (state == IDLE) ? grant : '0;
   assign take      = (state == IDLE) && any_valid;
   assign done      = (state == BUSY) && (div_out_valid || tmo);

`ifdef DIV_SHARE_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] tmo_cnt;
   // ISSUE always precedes BUSY, so clearing there is the clear-on-entry.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) tmo_cnt <= '0;
      else if (state == ISSUE) tmo_cnt <= '0;
      else if (state == BUSY) tmo_cnt <= tmo_cnt + 1'b1;
   end
   assign tmo = (state == BUSY) && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   // Watchdog absent: BUSY waits for the divider indefinitely.
   assign tmo = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) state <= IDLE;
      else state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = take ? ISSUE : IDLE;
         ISSUE:   state_nxt = BUSY;
         BUSY:    state_nxt = done ? RESP : BUSY;
         RESP:    state_nxt = rsp_ready ? IDLE : RESP;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         ptr             <= '0;
         id_q            <= '0;
         div_in_valid    <= 1'b0;
         div_numerator   <= '0;
         div_denominator <= '0;
         rsp_valid       <= 1'b0;
         rsp_id          <= '0;
         rsp_quotient    <= '0;
         rsp_error       <= 1'b0;
      end else begin
         div_in_valid <= take;
         if (take) begin
            div_numerator   <= req_num[winner*DATA_WIDTH +: DATA_WIDTH];
            div_denominator <= req_den[winner*DATA_WIDTH +: DATA_WIDTH];
            id_q            <= winner;
            ptr             <= (winner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
         end
         // A real completion wins over a watchdog expiry in the same cycle.
         if (done) begin
            rsp_quotient <= div_out_valid ? div_quotient : '0;
            rsp_error    <= div_out_valid ? div_error : 1'b1;
            rsp_id       <= id_q;
            rsp_valid    <= 1'b1;
         end
         if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_divider_share_arbiter.sv
// tb_divider_share_arbiter: randomized self-checking bench with a behavioural
// divider and a transaction-level arbitration/response model.
module tb_divider_share_arbiter;
   localparam int N = 4, DW = 32, IW = 2, TMO = 128;

   logic clk = 1'b0, arst_n = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]    req_valid = '0, req_ready;
   logic [N*DW-1:0] req_num = '0, req_den = '0;
   logic            rsp_valid, rsp_ready = 1'b1, rsp_error;
   logic [IW-1:0]   rsp_id;
   logic [DW-1:0]   rsp_quotient;
   logic            div_in_valid, div_out_valid, div_error;
   logic [DW-1:0]   div_numerator, div_denominator, div_quotient;

   int n_vec = 0, n_bad = 0;

   divider_share_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .arst_n(arst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_num(req_num), .req_den(req_den), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_quotient(rsp_quotient), .rsp_error(rsp_error),
      .div_in_valid(div_in_valid), .div_numerator(div_numerator),
      .div_denominator(div_denominator), .div_out_valid(div_out_valid),
      .div_quotient(div_quotient), .div_error(div_error)
   );

   // Q12.20 signed division reference: {error, quotient}.
   function automatic logic [32:0] ref_div(input logic [31:0] n, input logic [31:0] d);
      longint sn, sd, q;
      if (d == 32'h0) return {1'b1, 32'h0};
      sn = longint'($signed(n)) <<< 20;
      sd = longint'($signed(d));
      q  = sn / sd;
      return {1'b0, q[31:0]};
   endfunction

   // Behavioural divider: random latency, optionally silent, optional stray pulses.
   int          lat_min = 1, lat_max = 5, dcnt;
   bit          div_silent = 0, stray = 0, dpend;
   logic [31:0] dn, dd;
   always @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         dpend <= 0; dcnt <= 0; div_out_valid <= 0; div_quotient <= '0; div_error <= 0;
      end else begin
         div_out_valid <= 0;
         if (div_in_valid) begin
            dn <= div_numerator; dd <= div_denominator;
            dcnt <= $urandom_range(lat_max, lat_min); dpend <= !div_silent;
         end else if (dpend) begin
            if (dcnt <= 1) begin
               {div_error, div_quotient} <= ref_div(dn, dd);
               div_out_valid <= 1; dpend <= 0;
            end else dcnt <= dcnt - 1;
         end else if (stray) begin
            div_out_valid <= 1; div_quotient <= 32'hDEAD_BEEF; div_error <= 0;
         end
      end
   end

   // Transaction model: which requester should hold the grant, what the
   // divider must be handed, and what the response must carry.
   localparam int WAIT_REQ = 0, STARTING = 1, COMPUTING = 2, PRESENTING = 3;
   typedef struct {int id; logic [31:0] q; logic err;} rsp_t;
   typedef struct {int id; logic [31:0] num; logic [31:0] den;} op_t;
   rsp_t        rsp_log[$];
   op_t         pend[$];
   int          ph = WAIT_REQ, m_ptr = 0, busy_n = 0, n_pulse = 0;
   logic [IW-1:0] t_id;
   logic [31:0] t_num, t_den;
   logic [32:0] t_exp;
   logic [N-1:0] hs_last = '0;

   always @(negedge clk) begin
      logic [N-1:0] exp_rdy;
      int w;
      if (!arst_n) begin
         ph = WAIT_REQ; m_ptr = 0; hs_last = '0;
      end else begin
         w = -1;
         for (int k = 0; k < N; k++) if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
         exp_rdy = '0;
         if (ph == WAIT_REQ && w >= 0) exp_rdy[w] = 1'b1;
         n_vec++;
         if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL req_ready: got %b want %b @%0t", req_ready, exp_rdy, $time); end
         n_vec++;
         if (div_in_valid !== (ph == STARTING)) begin n_bad++; $display("FAIL div_in_valid: got %b want %b @%0t", div_in_valid, ph == STARTING, $time); end
         n_vec++;
         if (rsp_valid !== (ph == PRESENTING)) begin n_bad++; $display("FAIL rsp_valid: got %b want %b @%0t", rsp_valid, ph == PRESENTING, $time); end
         if (ph == STARTING) begin
            n_vec++;
            if ({div_numerator, div_denominator} !== {t_num, t_den}) begin
               n_bad++; $display("FAIL div_operands: got %h/%h want %h/%h @%0t", div_numerator, div_denominator, t_num, t_den, $time);
            end
         end
         if (ph == PRESENTING) begin
            n_vec++;
            if ({rsp_error, rsp_quotient} !== t_exp || rsp_id !== t_id) begin
               n_bad++; $display("FAIL rsp_fields: got id=%0d err=%b q=%h want id=%0d err=%b q=%h @%0t", rsp_id, rsp_error, rsp_quotient, t_id, t_exp[32], t_exp[31:0], $time);
            end
         end
         if (div_in_valid) n_pulse++;
         hs_last = req_valid & req_ready;
         if (rsp_valid && rsp_ready) rsp_log.push_back('{int'(rsp_id), rsp_quotient, rsp_error});
         case (ph)
            WAIT_REQ: if (w >= 0) begin
               t_id = IW'(w); t_num = req_num[w*DW +: DW]; t_den = req_den[w*DW +: DW];
               m_ptr = (w + 1) % N; ph = STARTING;
            end
            STARTING: begin ph = COMPUTING; busy_n = 0; end
            COMPUTING: begin
               busy_n++;
               if (div_out_valid) begin t_exp = ref_div(t_num, t_den); ph = PRESENTING; end
`ifdef DIV_SHARE_TIMEOUT_EN
               else if (busy_n == TMO) begin t_exp = {1'b1, 32'h0}; ph = PRESENTING; end
`endif
            end
            default: if (rsp_ready) ph = WAIT_REQ;
         endcase
      end
   end

   bit drop_en = 0, bp_hold = 0;
   int rdy_pct = 100;

   // One clock of stimulus: retire handshaken ops, present each requester's
   // oldest pending op (randomly withheld when drop_en), drive rsp_ready.
   task automatic run_cycle();
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
         int f;
         if (hs_last[i])
            for (int j = 0; j < pend.size(); j++) if (pend[j].id == i) begin pend.delete(j); break; end
         f = -1;
         for (int j = 0; j < pend.size(); j++) if (f < 0 && pend[j].id == i) f = j;
         req_valid[i] = (f >= 0) && !(drop_en && $urandom_range(3) == 0);
         req_num[i*DW +: DW] = (f >= 0) ? pend[f].num : $urandom;
         req_den[i*DW +: DW] = (f >= 0) ? pend[f].den : $urandom;
      end
      hs_last = '0;
      rsp_ready = !bp_hold && ($urandom_range(99) < rdy_pct);
   endtask

   task automatic wait_rsp(input int n, input int budget);
      int c = 0;
      while (rsp_log.size() < n && c < budget) begin run_cycle(); c++; end
      n_vec++;
      if (rsp_log.size() < n) begin n_bad++; $display("FAIL rsp_timeout: got %0d responses want %0d", rsp_log.size(), n); end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      arst_n = 0; req_valid = '0; pend.delete();
      repeat (2) @(posedge clk);
      #1 arst_n = 1;
   endtask

   task automatic test_reset();
      #2 arst_n = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if ({rsp_valid, rsp_id, rsp_quotient, rsp_error} !== '0) begin
         n_bad++; $display("FAIL reset_rsp: got v=%b id=%0d q=%h e=%b want all 0", rsp_valid, rsp_id, rsp_quotient, rsp_error);
      end
      n_vec++;
      if ({div_in_valid, div_numerator, div_denominator} !== '0) begin
         n_bad++; $display("FAIL reset_div: got v=%b n=%h d=%h want all 0", div_in_valid, div_numerator, div_denominator);
      end
      @(posedge clk); #1 arst_n = 1;
   endtask

   task automatic test_single();
      int p0 = n_pulse;
      rsp_log.delete();
      pend.push_back('{0, 32'h0030_0000, 32'h0020_0000});
      wait_rsp(1, 200);
      repeat (2) run_cycle();
      n_vec++;
      if (rsp_log.size() != 1 || rsp_log[0].id != 0 || rsp_log[0].q !== 32'h0018_0000 || rsp_log[0].err !== 1'b0) begin
         n_bad++; $display("FAIL single: got n=%0d id=%0d q=%h want n=1 id=0 q=00180000", rsp_log.size(), rsp_log[0].id, rsp_log[0].q);
      end
      n_vec++;
      if (n_pulse - p0 != 1) begin n_bad++; $display("FAIL single_pulses: got %0d want 1", n_pulse - p0); end
   endtask

   task automatic test_signed();
      rsp_log.delete();
      pend.push_back('{2, 32'hFFC0_0000, 32'h0020_0000});
      wait_rsp(1, 200);
      n_vec++;
      if (rsp_log[0].id != 2 || rsp_log[0].q !== 32'hFFE0_0000 || rsp_log[0].err !== 1'b0) begin
         n_bad++; $display("FAIL signed: got id=%0d q=%h e=%b want id=2 q=ffe00000 e=0", rsp_log[0].id, rsp_log[0].q, rsp_log[0].err);
      end
   endtask

   task automatic test_div_zero();
      rsp_log.delete();
      pend.push_back('{1, 32'h0050_0000, 32'h0});
      pend.push_back('{1, 32'h0010_0000, 32'h0040_0000});
      wait_rsp(2, 300);
      n_vec++;
      if (rsp_log[0].id != 1 || rsp_log[0].q !== 32'h0 || rsp_log[0].err !== 1'b1) begin
         n_bad++; $display("FAIL div_zero: got id=%0d q=%h e=%b want id=1 q=0 e=1", rsp_log[0].id, rsp_log[0].q, rsp_log[0].err);
      end
      n_vec++;
      if (rsp_log[1].id != 1 || rsp_log[1].q !== 32'h0004_0000 || rsp_log[1].err !== 1'b0) begin
         n_bad++; $display("FAIL after_zero: got id=%0d q=%h e=%b want id=1 q=00040000 e=0", rsp_log[1].id, rsp_log[1].q, rsp_log[1].err);
      end
   endtask

   task automatic test_fairness();
      do_reset();
      rsp_log.delete();
      for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) pend.push_back('{i, $urandom, $urandom});
      wait_rsp(2 * N, 600);
      for (int k = 0; k < 2 * N && k < rsp_log.size(); k++) begin
         n_vec++;
         if (rsp_log[k].id != k % N) begin n_bad++; $display("FAIL fair_order[%0d]: got %0d want %0d", k, rsp_log[k].id, k % N); end
      end
   endtask

   task automatic test_back_to_back();
      logic [34:0] snap;
      int c = 0;
      rsp_log.delete();
      bp_hold = 1;
      pend.push_back('{1, 32'h0030_0000, 32'h0020_0000});
      while (!rsp_valid && c < 100) begin run_cycle(); c++; end
      n_vec++;
      if (!rsp_valid) begin n_bad++; $display("FAIL bp_valid: got 0 want 1"); end
      snap = {rsp_id, rsp_error, rsp_quotient};
      pend.push_back('{2, 32'h0010_0000, 32'h0010_0000});
      repeat (10) begin
         run_cycle();
         n_vec++;
         if ({rsp_valid, rsp_id, rsp_error, rsp_quotient} !== {1'b1, snap} || req_ready !== '0 || div_in_valid !== 1'b0) begin
            n_bad++; $display("FAIL bp_hold: got v=%b rsp=%h rdy=%b div=%b want v=1 rsp=%h rdy=0 div=0", rsp_valid, {rsp_id, rsp_error, rsp_quotient}, req_ready, div_in_valid, snap);
         end
      end
      bp_hold = 0;
      wait_rsp(2, 200);
      n_vec++;
      if (rsp_log[1].id != 2 || rsp_log[1].q !== 32'h0010_0000) begin
         n_bad++; $display("FAIL bp_next: got id=%0d q=%h want id=2 q=00100000", rsp_log[1].id, rsp_log[1].q);
      end
   endtask

   task automatic test_random();
      int cnt[N];
      int got[N];
      rsp_log.delete();
      drop_en = 1; rdy_pct = 60;
      for (int i = 0; i < N; i++) begin cnt[i] = 0; got[i] = 0; end
      for (int k = 0; k < 150; k++) begin
         op_t o;
         o.id = $urandom_range(N - 1);
         o.num = $urandom;
         o.den = ($urandom_range(9) == 0) ? 32'h0 : $urandom;
         pend.push_back(o);
         cnt[o.id]++;
      end
      wait_rsp(150, 20000);
      foreach (rsp_log[k]) got[rsp_log[k].id]++;
      for (int i = 0; i < N; i++) begin
         n_vec++;
         if (got[i] != cnt[i]) begin n_bad++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, got[i], cnt[i]); end
      end
      drop_en = 0; rdy_pct = 100;
   endtask

   task automatic test_midop_reset();
      int p0 = n_pulse, c = 0;
      rsp_log.delete();
      lat_min = 30; lat_max = 30;
      pend.push_back('{0, 32'h0030_0000, 32'h0020_0000});
      while (n_pulse == p0 && c < 50) begin run_cycle(); c++; end
      repeat (3) run_cycle();
      do_reset();
      lat_min = 1; lat_max = 5;
      repeat (40) run_cycle();
      n_vec++;
      if (rsp_log.size() != 0) begin n_bad++; $display("FAIL midop_rsp: got %0d responses want 0", rsp_log.size()); end
      pend.push_back('{2, 32'h0020_0000, 32'h0010_0000});
      pend.push_back('{0, 32'h0010_0000, 32'h0010_0000});
      wait_rsp(2, 200);
      n_vec++;
      if (rsp_log[0].id != 0 || rsp_log[1].id != 2) begin
         n_bad++; $display("FAIL midop_ptr: got %0d,%0d want 0,2", rsp_log[0].id, rsp_log[1].id);
      end
   endtask

   task automatic test_timeout();
`ifdef DIV_SHARE_TIMEOUT_EN
      rsp_log.delete();
      div_silent = 1;
      pend.push_back('{3, 32'h0030_0000, 32'h0020_0000});
      wait_rsp(1, 400);
      div_silent = 0;
      n_vec++;
      if (rsp_log[0].id != 3 || rsp_log[0].q !== 32'h0 || rsp_log[0].err !== 1'b1) begin
         n_bad++; $display("FAIL timeout: got id=%0d q=%h e=%b want id=3 q=0 e=1", rsp_log[0].id, rsp_log[0].q, rsp_log[0].err);
      end
      stray = 1;
      repeat (5) run_cycle();
      stray = 0;
      repeat (5) run_cycle();
      n_vec++;
      if (rsp_log.size() != 1) begin n_bad++; $display("FAIL stray: got %0d responses want 1", rsp_log.size()); end
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_signed();
      test_div_zero();
      test_fairness();
      test_back_to_back();
      test_random();
      test_midop_reset();
      test_timeout();
      repeat (3) run_cycle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
